// File: rtl/aap_decode_pkg.sv
// Shared definitions for the aap decode stage: instruction class codes,
// decoder state encoding and the bit positions of the 16-bit word fields.
package aap_decode_pkg;

   // Instruction class codes carried in w0[14:13]
   localparam logic [1:0] CLS_ALU    = 2'b00;
   localparam logic [1:0] CLS_LDST   = 2'b01;
   localparam logic [1:0] CLS_BRANCH = 2'b10;
   localparam logic [1:0] CLS_MISC   = 2'b11;

   // Decoder state: is the older word an instruction start or a trailing half?
   typedef enum logic {
      S_FIRST = 1'b0,
      S_SKIP  = 1'b1
   } state_t;

   // Field bit positions inside one 16-bit instruction word
   localparam int LONG_BIT = 15;
   localparam int CLS_HI   = 14;
   localparam int CLS_LO   = 13;
   localparam int OPC_HI   = 12;
   localparam int OPC_LO   = 9;
   localparam int DST_HI   = 8;
   localparam int DST_LO   = 6;
   localparam int SRCA_HI  = 5;
   localparam int SRCA_LO  = 3;
   localparam int SRCB_HI  = 2;
   localparam int SRCB_LO  = 0;

   // A set long bit marks a word that opens a multi-word instruction
   function automatic logic is_long_word(input logic [15:0] word);
      return word[LONG_BIT];
   endfunction

endpackage

// File: rtl/aap_field_extract.sv
// Combinational field extraction: builds the decoded field set from the
// older word and, for 32-bit instructions, the low field bits of the newer word.
module aap_field_extract
   import aap_decode_pkg::*;
(
   input  logic [15:0] i_w0,
   input  logic [12:0] i_w1,
   input  logic        i_is_long,
   output logic [1:0]  o_class,
   output logic [7:0]  o_opcode,
   output logic [5:0]  o_dest,
   output logic [5:0]  o_srca,
   output logic [5:0]  o_srcb
);

   logic [3:0] w_upper_opc;
   logic [2:0] w_upper_dest;
   logic [2:0] w_upper_srca;
   logic [2:0] w_upper_srcb;
   logic       w_unused_long_bit;

   // The long bit itself is consumed by the FSM, not by the field mapping
   assign w_unused_long_bit = i_w0[LONG_BIT];

   // Upper field halves come from the newer word only for 32-bit instructions
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      w_upper_opc  = '0;
      w_upper_dest = '0;
      w_upper_srca = '0;
      w_upper_srcb = '0;
      if (i_is_long) begin
         w_upper_opc  = i_w1[OPC_HI:OPC_LO];
         w_upper_dest = i_w1[DST_HI:DST_LO];
         w_upper_srca = i_w1[SRCA_HI:SRCA_LO];
         w_upper_srcb = i_w1[SRCB_HI:SRCB_LO];
      end
   end

   assign o_class  = i_w0[CLS_HI:CLS_LO];
   assign o_opcode = {w_upper_opc,  i_w0[OPC_HI:OPC_LO]};
   assign o_dest   = {w_upper_dest, i_w0[DST_HI:DST_LO]};
   assign o_srca   = {w_upper_srca, i_w0[SRCA_HI:SRCA_LO]};
   assign o_srcb   = {w_upper_srcb, i_w0[SRCB_HI:SRCB_LO]};

endmodule

// File: rtl/aap_decode.sv
// Decode stage behind instruction fetch. Tracks whether the older word of
// the sliding pair starts an instruction, and registers the decoded fields
// one cycle after the pair is sampled.
module aap_decode
   import aap_decode_pkg::*;
#(
   parameter int PC_W  = 20,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      fetchoutput,
   input  logic [PC_W-1:0]  word_pc,
   input  logic             flush,
   output logic             dec_valid,
   output logic             dec_long,
   output logic [1:0]       dec_class,
   output logic [7:0]       dec_opcode,
   output logic [5:0]       dec_dest,
   output logic [5:0]       dec_srca,
   output logic [5:0]       dec_srcb,
   output logic [PC_W-1:0]  dec_pc,
   output logic             dec_illegal,
   output logic [CNT_W-1:0] dec_count
);

   state_t      r_state;
   state_t      w_next_state;

   logic [15:0] w_w0;
   logic [15:0] w_w1;
   logic        w_w0_long;
   logic        w_w1_long;
   logic        w_unused_w1_cls;

   logic        w_set_valid;
   logic        w_set_long;
   logic        w_set_illegal;

   logic [1:0]  w_class;
   logic [7:0]  w_opcode;
   logic [5:0]  w_dest;
   logic [5:0]  w_srca;
   logic [5:0]  w_srcb;

   assign w_w0      = fetchoutput[31:16];
   assign w_w1      = fetchoutput[15:0];
   assign w_w0_long = is_long_word(w_w0);
   assign w_w1_long = is_long_word(w_w1);

   // The newer word's class bits never reach the decoded fields
   assign w_unused_w1_cls = ^w_w1[CLS_HI:CLS_LO];

   aap_field_extract u_field_extract (
      .i_w0      (w_w0),
      .i_w1      (w_w1[OPC_HI:0]),
      .i_is_long (w_w0_long),
      .o_class   (w_class),
      .o_opcode  (w_opcode),
      .o_dest    (w_dest),
      .o_srca    (w_srca),
      .o_srcb    (w_srcb)
   );

   // State register; reset lands on an instruction boundary, dropping any pending half
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) r_state <= S_FIRST;
      else       r_state <= w_next_state;
   end

   // Next state: flush resynchronises, any start with the long bit set skips one word
   always_comb begin
      w_next_state = r_state;
      if (flush) begin
         w_next_state = S_FIRST;
      end else begin
         unique case (r_state)
            S_FIRST: if (w_w0_long) w_next_state = S_SKIP;
            S_SKIP:  w_next_state = S_FIRST;
            default: w_next_state = S_FIRST;
         endcase
      end
   end

   // Decode outcome for the current older word: 16-bit, 32-bit, bubble or illegal
   always_comb begin
      w_set_valid   = 1'b0;
      w_set_long    = 1'b0;
      w_set_illegal = 1'b0;
      if (!flush && r_state == S_FIRST && w_w0 != 16'h0000) begin
         if (!w_w0_long) begin
            w_set_valid = 1'b1;
         end else if (!w_w1_long) begin
            w_set_valid = 1'b1;
            w_set_long  = 1'b1;
         end else begin
            w_set_illegal = 1'b1;
         end
      end
   end

   // Output registers: pulses every cycle, fields and counter only on a valid decode
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dec_valid   <= 1'b0;
         dec_illegal <= 1'b0;
         dec_long    <= 1'b0;
         dec_class   <= '0;
         dec_opcode  <= '0;
         dec_dest    <= '0;
         dec_srca    <= '0;
         dec_srcb    <= '0;
         dec_pc      <= '0;
         dec_count   <= '0;
      end else begin
         dec_valid   <= w_set_valid;
         dec_illegal <= w_set_illegal;
         if (w_set_valid) begin
            dec_long   <= w_set_long;
            dec_class  <= w_class;
            dec_opcode <= w_opcode;
            dec_dest   <= w_dest;
            dec_srca   <= w_srca;
            dec_srcb   <= w_srcb;
            dec_pc     <= word_pc;
            dec_count  <= dec_count + 1'b1;
         end
      end
   end

endmodule
